// File: rtl/fa4_dual_adder_if.sv
// rtl/fa4_dual_adder_if.sv - operand/result bundle for the dual-path registered adder
interface fa4_dual_adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic [WIDTH-1:0] s1;
  logic             co1;
  logic [WIDTH-1:0] s2;
  logic             co2;
  logic             mismatch;
  logic             err_sticky;

  modport master (
    output a, b, ci,
    input  s1, co1, s2, co2, mismatch, err_sticky
  );

  modport slave (
    input  a, b, ci,
    output s1, co1, s2, co2, mismatch, err_sticky
  );
endinterface

// File: rtl/fa4_dual_adder.sv
// rtl/fa4_dual_adder.sv - registered adder computed by a ripple chain and a multi-bit add, cross-checked
module fa4_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module fa4_dual_adder #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fa4_dual_adder_if.slave bus
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s1_d, s2_d;
  logic             co1_d, co2_d;
  logic             mismatch_d, err_sticky_d;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic             co1_q, co2_q;
  logic             mismatch_q, err_sticky_q;

  assign carry[0] = bus.ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    fa4_fa_cell u_cell (
      .a_i (bus.a[i]),
      .b_i (bus.b[i]),
      .c_i (carry[i]),
      .s_o (s1_d[i]),
      .c_o (carry[i+1])
    );
  end

  assign co1_d = carry[WIDTH];

  // Operands widened to WIDTH+1 so the carry-out survives the add.
  assign {co2_d, s2_d} = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.ci};

  assign mismatch_d   = ({co1_d, s1_d} != {co2_d, s2_d});
  assign err_sticky_d = err_sticky_q | mismatch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      co1_q        <= 1'b0;
      s2_q         <= '0;
      co2_q        <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      co1_q        <= co1_d;
      s2_q         <= s2_d;
      co2_q        <= co2_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.s1         = s1_q;
  assign bus.co1        = co1_q;
  assign bus.s2         = s2_q;
  assign bus.co2        = co2_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_fa4_dual_adder.sv
// tb/tb_fa4_dual_adder.sv - table-driven and sequence checks for fa4_dual_adder
module tb_fa4_dual_adder;
  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[10];

  fa4_dual_adder_if #(.WIDTH(4)) bus ();

  fa4_dual_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] es, input logic eco,
                       input logic emis, input logic eerr);
    n_vec++;
    if (bus.s1 !== es || bus.co1 !== eco || bus.s2 !== es || bus.co2 !== eco ||
        bus.mismatch !== emis || bus.err_sticky !== eerr) begin
      n_bad++;
      $display("FAIL %s: got s1=%0d co1=%0b s2=%0d co2=%0b mis=%0b err=%0b, want s=%0d co=%0b mis=%0b err=%0b",
               name, bus.s1, bus.co1, bus.s2, bus.co2, bus.mismatch, bus.err_sticky,
               es, eco, emis, eerr);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    bus.a  = a;
    bus.b  = b;
    bus.ci = ci;
  endtask

  initial begin
    logic [4:0]  exp;
    logic [4:0]  prev;
    logic [3:0]  ra[10];
    logic [3:0]  rb[10];
    logic        rc[10];

    tbl[0] = '{"basic",    4'd3,  4'd4,  1'b0, 4'd7,  1'b0};
    tbl[1] = '{"ripple15", 4'd15, 4'd0,  1'b1, 4'd0,  1'b1};
    tbl[2] = '{"ripple78", 4'd7,  4'd8,  1'b1, 4'd0,  1'b1};
    tbl[3] = '{"zero",     4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
    tbl[4] = '{"max",      4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    tbl[5] = '{"cin_only", 4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
    tbl[6] = '{"no_carry", 4'd9,  4'd6,  1'b0, 4'd15, 1'b0};
    tbl[7] = '{"msb_cy",   4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
    tbl[8] = '{"alt_bits", 4'd10, 4'd5,  1'b1, 4'd0,  1'b1};
    tbl[9] = '{"mid",      4'd12, 4'd3,  1'b0, 4'd15, 1'b0};

    // Reset held with the clock running
    bus.a = 4'd9; bus.b = 4'd9; bus.ci = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release", 4'd3, 1'b1, 1'b0, 1'b0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].ci);
      @(posedge clk);
      #1 check(tbl[i].name, tbl[i].s, tbl[i].co, 1'b0, 1'b0);
    end

    // Exhaustive sweep, one operand set per cycle
    for (int k = 0; k < 512; k++) begin
      logic [8:0] v;
      v = 9'(k);
      drive(v[7:4], v[3:0], v[8]);
      exp = {1'b0, v[7:4]} + {1'b0, v[3:0]} + {4'b0, v[8]};
      @(posedge clk);
      #1 check("sweep", exp[3:0], exp[4], 1'b0, 1'b0);
    end

    // Back-to-back: outputs hold the previous result until the edge
    for (int i = 0; i < 10; i++) begin
      ra[i] = 4'($urandom_range(0, 15));
      rb[i] = 4'($urandom_range(0, 15));
      rc[i] = 1'($urandom_range(0, 1));
    end
    prev = {1'b0, 4'd15} + {1'b0, 4'd0} + 5'd0;
    drive(4'd15, 4'd0, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(ra[i], rb[i], rc[i]);
      #1 check("b2b_hold", prev[3:0], prev[4], 1'b0, 1'b0);
      exp = {1'b0, ra[i]} + {1'b0, rb[i]} + {4'b0, rc[i]};
      @(posedge clk);
      #1 check("b2b_new", exp[3:0], exp[4], 1'b0, 1'b0);
      prev = exp;
    end

    // Mid-stream asynchronous reset, then first edge captures live inputs
    drive(4'd7, 4'd8, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd6, 4'd5, 1'b0);
    rst_n = 1'b1;
    #1 check("reset_no_edge", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("post_reset", 4'd11, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fa4_dual_adder.md
Name: fa4_dual_adder

Overview:
- Registered 4-bit adder with carry-in and carry-out. The sum is computed by two independent structures:
  - Path 1: a ripple chain of 1-bit full-adder cells.
  - Path 2: a single multi-bit add expression.
- Both results are registered side by side, with a mismatch flag that cross-checks the two paths.
- Used as a datapath arithmetic primitive and as a self-checking reference for adder implementations.

Parameters:
- WIDTH, 4, operand and sum width in bits. Only 4 is required to be supported and verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ci  input  1  carry-in.
- s1  output  WIDTH  registered sum from the ripple-chain path.
- co1  output  1  registered carry-out from the ripple-chain path.
- s2  output  WIDTH  registered sum from the multi-bit path.
- co2  output  1  registered carry-out from the multi-bit path.
- mismatch  output  1  registered flag, 1 when {co1,s1} != {co2,s2} for the same operands.
- err_sticky  output  1  set on any mismatch; held until reset.

Behaviour:
- Reset, while rst_n=0 (asynchronous assert, no clock needed):
  - s1, co1, s2, co2, mismatch and err_sticky are all 0.
  - Release is synchronous to the next rising clk edge.
- Ripple path:
  - WIDTH instances of a 1-bit full-adder cell.
  - Cell i: sum_i = a[i]^b[i]^c_i; c_{i+1} = (a[i]&b[i]) | (c_i&(a[i]^b[i])).
  - c_0 = ci. Raw co1 = c_WIDTH.
- Multi-bit path: {co2,s2} raw = a + b + ci, evaluated at WIDTH+1 bits. No truncation of the carry.
- Both raw results are combinational from a, b and ci. They are captured into the output registers on every rising clk edge.
- Latency is exactly 1 cycle:
  - Inputs sampled at edge N appear on the outputs after edge N.
  - Outputs hold until the next edge.
- There is no enable and no handshake; the block accepts a new operand set every cycle.
- mismatch is registered in the same cycle as the sums, compared from the raw pre-register values. In a correct implementation it is always 0.
- err_sticky: set on the edge where raw mismatch is 1; cleared only by reset.
- Arithmetic is unsigned with no saturation:
  - Overflow wraps s to (a+b+ci) mod 16 and sets co=1.
  - Maximum result: a=15, b=15, ci=1 gives s=15, co=1.
- Reset asserted mid-stream clears every output immediately. The first post-reset edge captures the current inputs normally.
- X or Z on the inputs is not handled specially.

Test Plan:
- Reset: hold rst_n=0 with a=9, b=9, ci=1 and clock running -> all outputs 0. Release rst_n -> after the next edge s1=s2=3, co1=co2=1.
- Basic add: a=3, b=4, ci=0 -> after 1 edge s1=s2=7, co1=co2=0, mismatch=0.
- Carry ripple through all bits: a=15, b=0, ci=1 -> s=0, co=1. Then a=7, b=8, ci=1 -> s=0, co=1.
- Boundaries:
  - a=0, b=0, ci=0 -> s=0, co=0.
  - a=15, b=15, ci=1 -> s=15, co=1.
  - a=0, b=0, ci=1 -> s=1, co=0.
- Exhaustive sweep of all 512 {ci,a,b} combinations, one per cycle:
  - Check {co1,s1} = {co2,s2} = a+b+ci one cycle later.
  - mismatch and err_sticky stay 0 throughout.
- Back-to-back latency: change operands every cycle (for example the 10 randomized {ci,a,b} vectors) -> each result appears exactly one edge after its inputs with no dropped vectors. Assert rst_n=0 mid-sequence -> outputs go to 0 asynchronously.
